// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_AACK  = 3'd3,
    S_DATA  = 3'd4,
    S_DACK  = 3'd5,
    S_STOP  = 3'd6,
    S_BUF   = 3'd7
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t P0 = 2'd0;
  localparam phase_t P1 = 2'd1;
  localparam phase_t P2 = 2'd2;
  localparam phase_t P3 = 2'd3;

  localparam int BIT_CNT_W     = 3;
  localparam int BYTE_CNT_W    = 3;
  localparam int BITS_PER_BYTE = 8;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

  // Bus levels for one cycle: {scl, sda_low}. SCL is high in p2/p3 of ordinary slots.
  function automatic logic [1:0] bus_drive(input state_t st, input phase_t ph, input logic bit_v);
    logic [1:0] r;
    case (st)
      S_IDLE, S_BUF:  r = {1'b1, 1'b0};
      S_START:        r = {1'b1, ph[1]};
      S_ADDR, S_DATA: r = {ph[1], ~bit_v};
      S_AACK, S_DACK: r = {ph[1], 1'b0};
      S_STOP:         r = {ph[1], (ph != P3)};
      default:        r = {1'b1, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Divides CLK into SCL quarter-phases; tick marks the last cycle of each phase.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   i_hold,
  output logic   o_tick,
  output phase_t o_phase,
  output phase_t o_phase_nxt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  phase_t        r_phase;

  // Next divider count and phase; hold parks the generator at the start of p0.
  always_comb begin
    o_tick      = (r_div == DIV_LAST);
    w_div_nxt   = r_div;
    o_phase_nxt = r_phase;
    if (i_hold) begin
      w_div_nxt   = {DW{1'b0}};
      o_phase_nxt = P0;
    end else if (o_tick) begin
      w_div_nxt   = {DW{1'b0}};
      o_phase_nxt = r_phase + 2'd1;
    end else begin
      w_div_nxt   = r_div + DW'(1);
      o_phase_nxt = r_phase;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_div   <= {DW{1'b0}};
      r_phase <= P0;
    end else begin
      r_div   <= w_div_nxt;
      r_phase <= o_phase_nxt;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbitrated I2C write master: START, address byte, 0-7 data bytes, STOP.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  REQ,
  input  logic [15:0] ADDR,
  input  logic [5:0]  LEN,
  input  logic [15:0] WDATA,
  output logic [1:0]  GNT,
  output logic [1:0]  BYTE_TAKEN,
  output logic [1:0]  DONE,
  output logic        NACK,
  output logic        SCL,
  inout  wire         SDA
);

  state_t                r_state, w_state_nxt;
  logic                  r_win, w_win_nxt;
  logic                  r_ptr, w_ptr_nxt;
  logic [1:0]            r_gnt, w_gnt_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit, w_bit_nxt;
  logic [BYTE_CNT_W-1:0] r_bytes, w_bytes_nxt;
  logic                  r_nack_acc, w_nack_nxt;
  logic [1:0]            r_taken, w_taken_nxt;
  logic [1:0]            r_done, w_done_nxt;
  logic                  r_nack, w_nack_out_nxt;
  logic                  r_scl, r_sda_low;
  logic                  w_req_win;
  logic                  w_tick, w_slot_end, w_ack_sample;
  phase_t                w_phase, w_phase_nxt;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_hold      (r_state == S_IDLE),
    .o_tick      (w_tick),
    .o_phase     (w_phase),
    .o_phase_nxt (w_phase_nxt)
  );

  assign w_slot_end   = w_tick && (w_phase == P3);
  assign w_ack_sample = w_tick && (w_phase == P2);

  // Arbitration and transaction sequencing; every transition happens at a slot boundary.
  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_ptr_nxt      = r_ptr;
    w_gnt_nxt      = r_gnt;
    w_shift_nxt    = r_shift;
    w_bit_nxt      = r_bit;
    w_bytes_nxt    = r_bytes;
    w_nack_nxt     = r_nack_acc;
    w_taken_nxt    = 2'b00;
    w_done_nxt     = 2'b00;
    w_nack_out_nxt = 1'b0;
    w_req_win      = (REQ == 2'b11) ? r_ptr : REQ[1];
    case (r_state)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          w_state_nxt = S_START;
          w_win_nxt   = w_req_win;
          w_gnt_nxt   = w_req_win ? 2'b10 : 2'b01;
          w_shift_nxt = w_req_win ? ADDR[15:8] : ADDR[7:0];
          w_bytes_nxt = w_req_win ? LEN[5:3] : LEN[2:0];
          w_bit_nxt   = {BIT_CNT_W{1'b0}};
          w_nack_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_slot_end) w_state_nxt = S_ADDR;
        else            w_state_nxt = S_START;
      end
      S_ADDR, S_DATA: begin
        if (w_slot_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == LAST_BIT) w_state_nxt = (r_state == S_ADDR) ? S_AACK : S_DACK;
          else                   w_state_nxt = r_state;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_AACK, S_DACK: begin
        if (w_ack_sample) w_nack_nxt = r_nack_acc | SDA;
        else              w_nack_nxt = r_nack_acc;
        // A new data byte is latched on the same edge that enters DATA.
        if (w_slot_end) begin
          if (r_nack_acc || (r_bytes == {BYTE_CNT_W{1'b0}})) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
            w_shift_nxt = r_win ? WDATA[15:8] : WDATA[7:0];
            w_bytes_nxt = r_bytes - 3'd1;
            w_taken_nxt = r_gnt;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_STOP: begin
        if (w_slot_end) w_state_nxt = S_BUF;
        else            w_state_nxt = S_STOP;
      end
      S_BUF: begin
        if (w_slot_end) begin
          w_state_nxt    = S_IDLE;
          w_done_nxt     = r_gnt;
          w_nack_out_nxt = r_nack_acc;
          w_gnt_nxt      = 2'b00;
          w_ptr_nxt      = ~r_win;
        end else begin
          w_state_nxt = S_BUF;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and bus output registers; bus levels are precomputed for the coming cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_win      <= 1'b0;
      r_ptr      <= 1'b0;
      r_gnt      <= 2'b00;
      r_shift    <= 8'h00;
      r_bit      <= {BIT_CNT_W{1'b0}};
      r_bytes    <= {BYTE_CNT_W{1'b0}};
      r_nack_acc <= 1'b0;
      r_taken    <= 2'b00;
      r_done     <= 2'b00;
      r_nack     <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_low  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_win      <= w_win_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_shift    <= w_shift_nxt;
      r_bit      <= w_bit_nxt;
      r_bytes    <= w_bytes_nxt;
      r_nack_acc <= w_nack_nxt;
      r_taken    <= w_taken_nxt;
      r_done     <= w_done_nxt;
      r_nack     <= w_nack_out_nxt;
      {r_scl, r_sda_low} <= bus_drive(w_state_nxt, w_phase_nxt, w_shift_nxt[0]);
    end
  end

  assign GNT        = r_gnt;
  assign BYTE_TAKEN = r_taken;
  assign DONE       = r_done;
  assign NACK       = r_nack;
  assign SCL        = r_scl;
  assign SDA        = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with an ACKing slave model at address 8'h33.
module tb_i2c_master_arbiter;

  localparam logic [7:0] SLAVE_ADDR = 8'h33;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  REQ;
  logic [15:0] ADDR;
  logic [5:0]  LEN;
  logic [15:0] WDATA;
  wire  [1:0]  GNT, BYTE_TAKEN, DONE;
  wire         NACK, SCL;
  wire         sda;

  int checks = 0;
  int failures = 0;
  int taken0, taken1;
  bit step_en = 1'b0;

  logic       sl_low = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_addr_seen = 8'h00;
  int         sl_cnt = 0;
  bit         sl_act = 1'b0, sl_is_addr = 1'b0;
  logic [7:0] rx_q[$];

  pullup (sda);
  assign sda = sl_low ? 1'b0 : 1'bz;

  always #5 CLK = ~CLK;

  i2c_master_arbiter #(.CLK_DIV(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .ADDR       (ADDR),
    .LEN        (LEN),
    .WDATA      (WDATA),
    .GNT        (GNT),
    .BYTE_TAKEN (BYTE_TAKEN),
    .DONE       (DONE),
    .NACK       (NACK),
    .SCL        (SCL),
    .SDA        (sda)
  );

  // Slave model: watches bus levels once per cycle, captures LSB-first bytes, ACKs its address.
  always @(negedge CLK) begin
    if (!RST_N) begin
      sl_act = 1'b0; sl_low = 1'b0; sl_cnt = 0;
    end else if (prev_scl && SCL && prev_sda && !sda) begin
      sl_act = 1'b1; sl_is_addr = 1'b1; sl_cnt = 0; sl_low = 1'b0;
    end else if (prev_scl && SCL && !prev_sda && sda) begin
      sl_act = 1'b0; sl_low = 1'b0;
    end else if (sl_act && !prev_scl && SCL) begin
      if (sl_cnt < 8) begin
        sl_sh = {sda, sl_sh[7:1]};
        sl_cnt++;
      end
    end else if (sl_act && prev_scl && !SCL) begin
      if (sl_cnt == 8) begin
        sl_cnt = 9;
        if (sl_is_addr) begin
          sl_addr_seen = sl_sh;
          if (sl_sh == SLAVE_ADDR) sl_low = 1'b1;
          else sl_act = 1'b0;
        end else begin
          rx_q.push_back(sl_sh);
          sl_low = 1'b1;
        end
      end else if (sl_cnt == 9) begin
        sl_low = 1'b0; sl_cnt = 0; sl_is_addr = 1'b0;
      end
    end
    prev_scl = SCL;
    prev_sda = sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects the grant one cycle after REQ is presented, then times the DONE pulse from it.
  task automatic run_txn(input string tag, input logic [1:0] exp_gnt, input int exp_cycles,
                         input logic exp_nack, input bit drop);
    int cyc;
    logic [1:0] dv;
    logic nv;
    @(negedge CLK);
    check({tag, " gnt"}, {30'd0, GNT}, {30'd0, exp_gnt});
    if (drop) REQ = 2'b00;
    cyc = 0; dv = 2'b00; nv = 1'b0; taken0 = 0; taken1 = 0;
    while (cyc < 2000 && dv == 2'b00) begin
      @(negedge CLK);
      cyc++;
      if (BYTE_TAKEN[0]) begin
        taken0++;
        if (step_en) WDATA[7:0] = WDATA[7:0] + 8'd1;
      end
      if (BYTE_TAKEN[1]) taken1++;
      if (DONE != 2'b00) begin
        dv = DONE;
        nv = NACK;
      end
    end
    check({tag, " cycles"}, cyc, exp_cycles);
    check({tag, " done"}, {30'd0, dv}, {30'd0, exp_gnt});
    check({tag, " nack"}, {31'd0, nv}, {31'd0, exp_nack});
    check({tag, " gnt_drop"}, {30'd0, GNT}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; REQ = 2'b00; ADDR = 16'h0000; LEN = 6'd0; WDATA = 16'h0000;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check("reset_idle", {23'd0, SCL, sda, GNT, BYTE_TAKEN, DONE, NACK}, 32'h180);
    end

    // One data byte to the ACKing slave.
    ADDR = 16'h0033; LEN = 6'd1; WDATA = 16'h00A5; rx_q.delete(); REQ = 2'b01;
    run_txn("wr_a5", 2'b01, 336, 1'b0, 1'b1);
    check("wr_a5 taken0", taken0, 32'd1);
    check("wr_a5 addr", {24'd0, sl_addr_seen}, 32'h33);
    check("wr_a5 rx_n", rx_q.size(), 32'd1);
    check("wr_a5 rx0", {24'd0, rx_q[0]}, 32'hA5);

    // Wrong address: no ACK, no data phase.
    ADDR = 16'h0034; rx_q.delete(); REQ = 2'b01;
    run_txn("nack_addr", 2'b01, 192, 1'b1, 1'b1);
    check("nack_addr taken0", taken0, 32'd0);
    check("nack_addr addr", {24'd0, sl_addr_seen}, 32'h34);
    check("nack_addr rx_n", rx_q.size(), 32'd0);

    // Both requesting from reset: grants alternate 0,1,0,1.
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    ADDR = 16'h3333; LEN = {3'd0, 3'd1}; WDATA = 16'h00A5; REQ = 2'b11;
    run_txn("rr0", 2'b01, 336, 1'b0, 1'b0);
    run_txn("rr1", 2'b10, 192, 1'b0, 1'b0);
    check("rr1 taken1", taken1, 32'd0);
    run_txn("rr2", 2'b01, 336, 1'b0, 1'b0);
    run_txn("rr3", 2'b10, 192, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check("rr idle", {30'd0, GNT}, 32'd0);

    // Address-only probe, then seven bytes stepping on BYTE_TAKEN.
    ADDR = 16'h0033; LEN = 6'd0; rx_q.delete(); REQ = 2'b01;
    run_txn("probe", 2'b01, 192, 1'b0, 1'b1);
    check("probe taken0", taken0, 32'd0);
    check("probe rx_n", rx_q.size(), 32'd0);
    LEN = 6'd7; WDATA = 16'h0001; step_en = 1'b1; rx_q.delete(); REQ = 2'b01;
    run_txn("len7", 2'b01, 1200, 1'b0, 1'b1);
    step_en = 1'b0;
    check("len7 taken0", taken0, 32'd7);
    check("len7 rx_n", rx_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) check("len7 rx", {24'd0, rx_q[i]}, i + 1);

    // Reset during DATA bit 4 (slot 14, cycle 230 is in p1), then a clean transaction.
    ADDR = 16'h0033; LEN = 6'd1; WDATA = 16'h00C3; rx_q.delete(); REQ = 2'b01;
    @(negedge CLK);
    check("rst_mid gnt", {30'd0, GNT}, 32'd1);
    REQ = 2'b00;
    repeat (230) @(negedge CLK);
    check("rst_mid scl_low", {31'd0, SCL}, 32'd0);
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_mid release", {28'd0, SCL, sda, GNT}, 32'hC);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    WDATA = 16'h005A; rx_q.delete(); REQ = 2'b01;
    run_txn("after_rst", 2'b01, 336, 1'b0, 1'b1);
    check("after_rst rx_n", rx_q.size(), 32'd1);
    check("after_rst rx0", {24'd0, rx_q[0]}, 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
